// File: rtl/des_job_controller.sv
// des_job_controller
// Sequences a pipelined DES core between a byte assembler (64-bit words in)
// and a serializer (64-bit words out). A header word selects a key load or an
// encrypt/decrypt job of N blocks. Data blocks are issued to the core under
// credit control. Results are buffered in a small FIFO and handed to the
// serializer one word at a time.
//
// Ports
//   clk_i            system clock, rising edge
//   rst_ni           asynchronous active-low reset
//   word_in_i        assembled 64-bit word
//   word_valid_i     one-cycle strobe, word_in_i valid
//   key_out_o        DES key register
//   key_load_o       one-cycle pulse when key_out_o is updated
//   mode_o           0 = encrypt, 1 = decrypt, stable for a whole job
//   des_in_o         block to the DES core
//   des_in_valid_o   one-cycle issue strobe
//   des_out_i        DES result
//   des_out_valid_i  result strobe (any fixed pipeline latency)
//   tx_word_o        word to the serializer
//   tx_start_o       one-cycle start pulse
//   tx_busy_i        serializer busy, rises the cycle after tx_start_o
//   busy_o           high whenever the controller is not idle
//   done_o           one-cycle pulse at job completion
//   err_o            sticky error flag

// Guards the result FIFO against a push into a full buffer.
module des_job_controller_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic push_i,
  input logic pop_i,
  input logic full_i
);
  // Credit control must never let a result land in a full FIFO.
  no_overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(push_i && full_i && !pop_i));
endmodule

module des_job_controller #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [63:0] word_in_i,
  input  logic        word_valid_i,
  output logic [63:0] key_out_o,
  output logic        key_load_o,
  output logic        mode_o,
  output logic [63:0] des_in_o,
  output logic        des_in_valid_o,
  input  logic [63:0] des_out_i,
  input  logic        des_out_valid_i,
  output logic [63:0] tx_word_o,
  output logic        tx_start_o,
  input  logic        tx_busy_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [7:0] OP_KEY = 8'hA5;
  localparam logic [7:0] OP_ENC = 8'hE1;
  localparam logic [7:0] OP_DEC = 8'hD1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GET_KEY = 2'd1,
    S_RUN     = 2'd2,
    S_DRAIN   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [63:0]   key_q, key_d;
  logic          key_load_q, key_load_d;
  logic          mode_q, mode_d;
  logic [63:0]   des_in_q, des_in_d;
  logic          des_in_valid_q, des_in_valid_d;
  logic [63:0]   tx_word_q, tx_word_d;
  logic          tx_start_q, tx_start_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    remaining_q, remaining_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          pend_valid_q, pend_valid_d;
  logic [63:0]   pend_word_q, pend_word_d;
  logic [63:0]   mem_q [FIFO_DEPTH];

  logic          credit_s;
  logic          push_s;
  logic          pop_s;
  logic          issue_s;
  logic          data_word_s;
  logic          full_s;
  logic [7:0]    opcode_s;
  logic [7:0]    nblk_s;

  assign opcode_s = word_in_i[63:56];
  assign nblk_s   = word_in_i[7:0];
  assign full_s   = (count_q == CW'(FIFO_DEPTH));

  // Next-state logic for the job FSM, credit accounting and result FIFO.
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    key_load_d   = 1'b0;
    mode_d       = mode_q;
    des_in_d     = des_in_q;
    tx_word_d    = tx_word_q;
    tx_start_d   = 1'b0;
    done_d       = 1'b0;
    err_d        = err_q;
    remaining_d  = remaining_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pend_valid_d = pend_valid_q;
    pend_word_d  = pend_word_q;
    issue_s      = 1'b0;

    // Every block in flight or buffered owns one FIFO slot.
    credit_s = ({1'b0, inflight_q} + {1'b0, count_q}) < (CW + 1)'(FIFO_DEPTH);
    // A result with nothing in flight is left over from before a reset.
    push_s   = des_out_valid_i && (inflight_q != CW'(0));
    // tx_busy_i lags tx_start_o by a cycle, so never start twice in a row.
    pop_s    = (count_q != CW'(0)) && !tx_busy_i && !tx_start_q;
    data_word_s = word_valid_i && (remaining_q != 8'd0);

    if (pop_s) begin
      tx_word_d  = mem_q[rd_ptr_q];
      tx_start_d = 1'b1;
      rd_ptr_d   = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d   = rd_ptr_q;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (word_valid_i) begin
          case (opcode_s)
            OP_KEY: state_d = S_GET_KEY;
            OP_ENC, OP_DEC: begin
              if (nblk_s != 8'd0) begin
                state_d     = S_RUN;
                mode_d      = (opcode_s == OP_DEC);
                remaining_d = nblk_s;
                err_d       = 1'b0;
              end else begin
                err_d       = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end

      S_GET_KEY: begin
        if (word_valid_i) begin
          key_d      = word_in_i;
          key_load_d = 1'b1;
          err_d      = 1'b0;
          state_d    = S_IDLE;
        end else begin
          state_d    = S_GET_KEY;
        end
      end

      S_RUN: begin
        if (pend_valid_q && credit_s) begin
          // The held word goes out; a new word takes its place in the slot.
          issue_s      = 1'b1;
          des_in_d     = pend_word_q;
          pend_valid_d = data_word_s;
          if (data_word_s) begin
            pend_word_d = word_in_i;
            remaining_d = remaining_q - 8'd1;
          end else begin
            remaining_d = remaining_q;
          end
        end else if (pend_valid_q) begin
          // No room anywhere: the new word is lost but still counted.
          if (data_word_s) begin
            err_d       = 1'b1;
            remaining_d = remaining_q - 8'd1;
          end else begin
            remaining_d = remaining_q;
          end
        end else if (data_word_s) begin
          remaining_d = remaining_q - 8'd1;
          if (credit_s) begin
            issue_s      = 1'b1;
            des_in_d     = word_in_i;
          end else begin
            pend_valid_d = 1'b1;
            pend_word_d  = word_in_i;
          end
        end else begin
          remaining_d = remaining_q;
        end
        // Words beyond the job length while the last one waits are discarded.
        if (word_valid_i && (remaining_q == 8'd0)) begin
          err_d = 1'b1;
        end else begin
          err_d = err_d;
        end
        if ((remaining_d == 8'd0) && !pend_valid_d) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RUN;
        end
      end

      S_DRAIN: begin
        if (word_valid_i) begin
          err_d = 1'b1;
        end else begin
          err_d = err_d;
        end
        // Wait until the serializer has actually taken the last word.
        if ((inflight_q == CW'(0)) && (count_q == CW'(0)) && !tx_busy_i && !tx_start_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end

      default: state_d = S_IDLE;
    endcase

    des_in_valid_d = issue_s;
    busy_d         = (state_d != S_IDLE);

    case ({issue_s, push_s})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      key_q          <= 64'd0;
      key_load_q     <= 1'b0;
      mode_q         <= 1'b0;
      des_in_q       <= 64'd0;
      des_in_valid_q <= 1'b0;
      tx_word_q      <= 64'd0;
      tx_start_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      remaining_q    <= 8'd0;
      inflight_q     <= '0;
      count_q        <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      pend_valid_q   <= 1'b0;
      pend_word_q    <= 64'd0;
    end else begin
      state_q        <= state_d;
      key_q          <= key_d;
      key_load_q     <= key_load_d;
      mode_q         <= mode_d;
      des_in_q       <= des_in_d;
      des_in_valid_q <= des_in_valid_d;
      tx_word_q      <= tx_word_d;
      tx_start_q     <= tx_start_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      remaining_q    <= remaining_d;
      inflight_q     <= inflight_d;
      count_q        <= count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      pend_valid_q   <= pend_valid_d;
      pend_word_q    <= pend_word_d;
    end
  end

  // FIFO storage; contents are only meaningful behind count_q.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= des_out_i;
    end
  end

  des_job_controller_chk u_chk (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push_s),
    .pop_i  (pop_s),
    .full_i (full_s)
  );

  assign key_out_o      = key_q;
  assign key_load_o     = key_load_q;
  assign mode_o         = mode_q;
  assign des_in_o       = des_in_q;
  assign des_in_valid_o = des_in_valid_q;
  assign tx_word_o      = tx_word_q;
  assign tx_start_o     = tx_start_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;

endmodule

// File: doc/des_job_controller.md
# des_job_controller

Sequences the pipelined DES core between the serial front end and back end. Takes 64-bit words from the 8-to-64 byte assembler, decodes a header word into a key-load or an encrypt/decrypt job of N blocks, and issues data blocks to the DES pipeline under credit control. Buffers results in a small FIFO and hands them one at a time to the 64-to-8 serializer/UART transmitter.

## Interface
- FIFO_DEPTH, 4: result FIFO entries; power of two, 2..16; also the maximum number of blocks in flight plus buffered.
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- word_in  in  64  assembled word from byte assembler
- word_valid  in  1  one-cycle pulse, word_in valid
- key_out  out  64  DES key register
- key_load  out  1  one-cycle pulse, key_out updated
- mode  out  1  0 = encrypt, 1 = decrypt; stable for a whole job
- des_in  out  64  block to DES core
- des_in_valid  out  1  one-cycle issue strobe
- des_out  in  64  DES result
- des_out_valid  in  1  result strobe, any fixed pipeline latency
- tx_word  out  64  word to serializer
- tx_start  out  1  one-cycle start pulse
- tx_busy  in  1  serializer busy; rises the cycle after tx_start
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at job completion
- err  out  1  sticky error flag

## Operation
- Header word: word_in[63:56] opcode, word_in[7:0] block count N; other bits ignored.
- Opcodes: 8'hA5 = key load; 8'hE1 = encrypt N blocks; 8'hD1 = decrypt N blocks.
- States: IDLE, GET_KEY, RUN, DRAIN.
- IDLE + word_valid with opcode A5 -> GET_KEY. E1/D1 with N != 0 -> RUN; mode is set, remaining = N, err is cleared. Any other opcode, or N == 0 -> stay in IDLE, set err, discard the word.
- GET_KEY + word_valid -> key_out <= word_in, key_load pulses, err is cleared, return to IDLE.
- RUN: each word_valid is a data block. Issue it when credit allows: inflight + fifo_count < FIFO_DEPTH.
- If there is no credit, hold the word in a one-entry pending register and issue it on the first cycle credit exists.
- A word_valid while pending is full drops the new word and sets err. The dropped word still counts against remaining.
- remaining decrements on each accepted or dropped data word. When it reaches 0, move to DRAIN after the last word is issued.
- inflight: +1 on issue, -1 on des_out_valid, unchanged if both occur in the same cycle.
- des_out_valid writes des_out to the FIFO. If inflight == 0 (stale result after reset), the result is ignored and inflight stays 0.
- TX: when the FIFO is non-empty, tx_busy = 0, and tx_start was not asserted in the previous cycle, pulse tx_start with tx_word = FIFO head and pop the head.
- DRAIN: when inflight == 0, the FIFO is empty, and tx_busy == 0, pulse done and go to IDLE.
- Header words arriving in RUN/DRAIN are data (RUN) or ignored (DRAIN). An ignored word in DRAIN sets err.

## Timing
- Reset values: state IDLE; key_out, des_in, tx_word = 0; all strobes, mode, busy, err = 0; FIFO empty; counters 0.
- Reset mid-job: all of the above immediately, FIFO flushed, pending register cleared.
- Issue latency: des_in_valid is registered, one cycle after the accepting word_valid when credit is available.
- key_load is asserted in the cycle after the key word_valid.
- busy and mode update in the cycle after the header word_valid.
- FIFO write to tx_start is at least 1 cycle (registered head).
- Minimum tx_start spacing is 2 cycles, with further spacing governed by tx_busy.
- Simultaneous FIFO push and pop on a full FIFO is legal because credit guarantees no overflow. A push to a full FIFO is an assertion failure.
- done is asserted in the cycle after the DRAIN exit condition holds; busy falls in that same cycle.
- word_valid may arrive on consecutive cycles.

## Test plan
- Key load: header 64'hA500_0000_0000_0000 then 64'h1334_5779_9BBC_DFF1 -> one key_load pulse, key_out = 64'h133457799BBCDFF1, err = 0.
- Encrypt 3 blocks, DES model latency 16, tx_busy held 100 cycles per word -> 3 des_in_valid with mode = 0, 3 tx_start in order with correct results, single done, inflight + FIFO count never > 4.
- Credit stall: FIFO_DEPTH = 4, tx_busy held high, 6 back-to-back words in a job with N = 6 -> 4 issued, 5th pending, 6th dropped, err = 1. After tx_busy falls, the pending word issues and done occurs after 5 transmits.
- Bad header: opcode 8'h77, then E1 with N = 0 -> err = 1 after each, state stays IDLE. A subsequent valid D1/N = 1 clears err and mode = 1.
- Reset mid-RUN with 2 results in flight -> all outputs 0 next cycle; late des_out_valid strobes cause no FIFO write or tx_start.
- Simultaneous issue and des_out_valid -> inflight unchanged.
